// File: rtl/crm_pkg.sv
// rtl/crm_pkg.sv - shared constants and types for the CRM sequencing controller
`timescale 1ns/1ps
package crm_pkg;

  localparam int CRM_N_DOM       = 8;
  localparam int CRM_RST_HOLD    = 16;
  localparam int CRM_TIMEOUT     = 1024;
  localparam int CRM_SYNC_STAGES = 2;

  // State codes are visible to software through o_err_state, so they are fixed.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GATE    = 3'd1;
  localparam logic [2:0] ST_RST_ON  = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RST_OFF = 3'd4;
  localparam logic [2:0] ST_UNGATE  = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  typedef logic [2:0]           crm_state_t;
  typedef logic [CRM_N_DOM-1:0] crm_mask_t;

endpackage

// File: rtl/crm_ack_sync.sv
// rtl/crm_ack_sync.sv - multi-bit flop-chain synchronizer for CRM acknowledge levels
`timescale 1ns/1ps
module crm_ack_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  // Each bit is an independent level; no cross-bit coherency is assumed.
  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= i_async;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign o_sync = stage_q[STAGES-1];

endmodule

// File: rtl/crm_seq_ctrl.sv
// rtl/crm_seq_ctrl.sv - gate/reset/hold/release/ungate sequencer toward the clock/reset manager
`timescale 1ns/1ps
module crm_seq_ctrl
  import crm_pkg::*;
#(
  parameter int N_DOM       = CRM_N_DOM,
  parameter int RST_HOLD    = CRM_RST_HOLD,
  parameter int TIMEOUT     = CRM_TIMEOUT,
  parameter int SYNC_STAGES = CRM_SYNC_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_req,
  input  logic [N_DOM-1:0] i_mask,
  input  logic [N_DOM-1:0] i_clk_ack,
  input  logic [N_DOM-1:0] i_rst_ack,
  input  logic             i_err_clr,
  output logic [N_DOM-1:0] o_clk_en,
  output logic [N_DOM-1:0] o_rst_req,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [2:0]       o_err_state
);

  localparam int CNT_MAX = (TIMEOUT > RST_HOLD) ? TIMEOUT : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

  crm_state_t       state, state_nxt;
  logic [N_DOM-1:0] mask_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_DOM-1:0] clk_ack_s, rst_ack_s;
  logic             timeout;
  logic             at_to;

  crm_ack_sync #(.WIDTH(N_DOM), .STAGES(SYNC_STAGES)) u_clk_ack_sync (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_async (i_clk_ack),
    .o_sync  (clk_ack_s)
  );

  crm_ack_sync #(.WIDTH(N_DOM), .STAGES(SYNC_STAGES)) u_rst_ack_sync (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_async (i_rst_ack),
    .o_sync  (rst_ack_s)
  );

  assign at_to = (cnt_q == TO_LAST);

  // Waits compare only the masked domains; other domains are ignored entirely.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req) state_nxt = (i_mask == '0) ? ST_DONE : ST_GATE;
      end
      ST_GATE: begin
        if ((clk_ack_s & mask_q) == '0) state_nxt = ST_RST_ON;
        else if (at_to)                 timeout   = 1'b1;
      end
      ST_RST_ON: begin
        if ((rst_ack_s & mask_q) == mask_q) state_nxt = ST_HOLD;
        else if (at_to)                     timeout   = 1'b1;
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) state_nxt = ST_RST_OFF;
      end
      ST_RST_OFF: begin
        if ((rst_ack_s & mask_q) == '0) state_nxt = ST_UNGATE;
        else if (at_to)                 timeout   = 1'b1;
      end
      ST_UNGATE: begin
        if ((clk_ack_s & mask_q) == mask_q) state_nxt = ST_DONE;
        else if (at_to)                     timeout   = 1'b1;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (timeout) state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= ST_HOLD;
      mask_q <= '1;
      cnt_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && i_req) mask_q <= i_mask;
      if (state_nxt != state)  cnt_q <= '0;
      else if (cnt_q != '1)    cnt_q <= cnt_q + 1'b1;
    end
  end

  // Outputs follow the state one cycle late and only ever touch masked bits.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_clk_en  <= '0;
      o_rst_req <= '1;
      o_busy    <= 1'b1;
      o_done    <= 1'b0;
    end else begin
      case (state)
        ST_GATE:    o_clk_en  <= o_clk_en & ~mask_q;
        ST_RST_ON:  o_rst_req <= o_rst_req | mask_q;
        ST_RST_OFF: o_rst_req <= o_rst_req & ~mask_q;
        ST_UNGATE:  o_clk_en  <= o_clk_en | mask_q;
        default: ;
      endcase
      o_busy <= (state_nxt != ST_IDLE);
      o_done <= (state == ST_DONE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_err       <= 1'b0;
      o_err_state <= 3'd0;
    end else if (timeout) begin
      o_err       <= 1'b1;
      o_err_state <= state;
    end else if (i_err_clr) begin
      o_err       <= 1'b0;
      o_err_state <= 3'd0;
    end
  end

endmodule

// File: tb/tb_crm_seq_ctrl.sv
// tb/tb_crm_seq_ctrl.sv - self-checking bench for crm_seq_ctrl with a delayed-ack CRM model
`timescale 1ns/1ps
module tb_crm_seq_ctrl;

  localparam int N_DOM    = 8;
  localparam int RST_HOLD = 16;
  localparam int TIMEOUT  = 1024;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_req = 1'b0;
  logic [7:0] i_mask = 8'h00;
  logic [7:0] clk_ack, rst_ack;
  logic       i_err_clr = 1'b0;
  logic [7:0] o_clk_en, o_rst_req;
  logic       o_busy, o_done, o_err;
  logic [2:0] o_err_state;

  int total = 0;
  int bad = 0;

  crm_seq_ctrl #(.N_DOM(N_DOM), .RST_HOLD(RST_HOLD), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_req       (i_req),
    .i_mask      (i_mask),
    .i_clk_ack   (clk_ack),
    .i_rst_ack   (rst_ack),
    .i_err_clr   (i_err_clr),
    .o_clk_en    (o_clk_en),
    .o_rst_req   (o_rst_req),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_err_state (o_err_state)
  );

  always #5 clk = ~clk;

  // CRM model: acks follow the requests after ack_dly cycles; domain 2 clock can be held running.
  logic [7:0] ce_h [8] = '{default: 8'h00};
  logic [7:0] rr_h [8] = '{default: 8'hFF};
  int         ack_dly = 3;
  logic       withhold = 1'b0;

  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      ce_h[i] <= ce_h[i-1];
      rr_h[i] <= rr_h[i-1];
    end
    ce_h[0] <= o_clk_en;
    rr_h[0] <= o_rst_req;
  end

  always_comb begin
    clk_ack = ce_h[ack_dly-1] | (withhold ? 8'h04 : 8'h00);
    rst_ack = rr_h[ack_dly-1];
  end

  // Monitor: distinct output snapshots, done pulses, and cycles spent at the hold value.
  logic [15:0] snaps [$];
  logic [15:0] exp_q [$];
  int          done_cnt = 0;
  int          hold_cnt = 0;
  logic [7:0]  hold_val = 8'h00;

  always begin
    @(posedge clk);
    #2;
    if (snaps.size() == 0 || snaps[$] != {o_clk_en, o_rst_req}) snaps.push_back({o_clk_en, o_rst_req});
    if (o_done) done_cnt++;
    if (hold_val != 8'h00 && o_rst_req == hold_val) hold_cnt++;
  end

  logic [7:0] m_ce = 8'h00;
  logic [7:0] m_rr = 8'hFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear(input logic [7:0] hv);
    snaps.delete();
    snaps.push_back({o_clk_en, o_rst_req});
    exp_q.delete();
    exp_q.push_back({m_ce, m_rr});
    done_cnt = 0;
    hold_cnt = 0;
    hold_val = hv;
  endtask

  task automatic add_exp();
    if (exp_q[$] != {m_ce, m_rr}) exp_q.push_back({m_ce, m_rr});
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_cnt > 0) break;
    end
    chk({tag, "_done_in_time"}, k < budget, 1);
  endtask

  task automatic finish_check(input string tag);
    int n;
    repeat (20) @(negedge clk);
    chk({tag, "_snap_count"}, snaps.size(), exp_q.size());
    n = (snaps.size() < exp_q.size()) ? snaps.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_snap%0d", tag, i), snaps[i], exp_q[i]);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_hold_len"}, hold_cnt >= RST_HOLD, 1);
    chk({tag, "_err"}, o_err, 0);
  endtask

  task automatic build_exp(input logic [7:0] m);
    m_ce &= ~m; add_exp();
    m_rr |= m;  add_exp();
    m_rr &= ~m; add_exp();
    m_ce |= m;  add_exp();
  endtask

  task automatic boot(input string tag);
    m_ce = 8'h00;
    m_rr = 8'hFF;
    mon_clear(8'hFF);
    m_rr = 8'h00; add_exp();
    m_ce = 8'hFF; add_exp();
    @(negedge clk);
    rstn = 1'b1;
    wait_done(tag, 300);
    finish_check(tag);
  endtask

  task automatic run_seq(input string tag, input logic [7:0] m, input bit poke);
    ack_dly = $urandom_range(1, 6);
    mon_clear(m);
    build_exp(m);
    @(negedge clk);
    i_req = 1'b1; i_mask = m;
    @(negedge clk);
    i_req = 1'b0; i_mask = $urandom;
    if (poke) begin
      repeat (4) @(negedge clk);
      i_req = 1'b1; i_mask = 8'h01;
      @(negedge clk);
      i_req = 1'b0;
    end
    wait_done(tag, 400);
    finish_check(tag);
  endtask

  initial begin
    int k;
    repeat (4) @(negedge clk);
    chk("rst_clk_en", o_clk_en, 8'h00);
    chk("rst_rst_req", o_rst_req, 8'hFF);
    chk("rst_busy", o_busy, 1);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_err_state", o_err_state, 0);

    boot("boot");

    run_seq("mask05", 8'h05, 1'b0);
    for (int r = 0; r < 3; r++) run_seq($sformatf("rand%0d", r), 8'($urandom_range(1, 255)), 1'b0);
    run_seq("busy_ignore", 8'h30, 1'b1);

    // Empty mask completes without touching outputs.
    mon_clear(8'h00);
    @(negedge clk);
    i_req = 1'b1; i_mask = 8'h00;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) i_req = 1'b0;
      if (o_done) break;
    end
    chk("mask0_done_latency", k, 2);
    repeat (5) @(negedge clk);
    chk("mask0_snaps", snaps.size(), 1);
    chk("mask0_busy", o_busy, 0);

    // Domain 2 clock never stops: GATE must time out.
    withhold = 1'b1;
    mon_clear(8'h00);
    @(negedge clk);
    i_req = 1'b1; i_mask = 8'h04;
    for (k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (k == 1) i_req = 1'b0;
      if (o_err) break;
    end
    chk("to_latency", k, TIMEOUT + 1);
    chk("to_err", o_err, 1);
    chk("to_err_state", o_err_state, 1);
    repeat (2) @(negedge clk);
    chk("to_busy", o_busy, 0);
    chk("to_clk_en", o_clk_en, 8'hFB);
    chk("to_rst_req", o_rst_req, 8'h00);
    chk("to_no_done", done_cnt, 0);
    m_ce = 8'hFB;
    withhold = 1'b0;
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    chk("clr_err", o_err, 0);
    chk("clr_err_state", o_err_state, 0);

    run_seq("recover", 8'h04, 1'b0);

    // Reset during HOLD of a soft reset.
    @(negedge clk);
    i_req = 1'b1; i_mask = 8'h05;
    @(negedge clk);
    i_req = 1'b0;
    for (k = 0; k < 100; k++) begin
      if (o_rst_req == 8'h05) break;
      @(negedge clk);
    end
    chk("mid_reach_rst_on", k < 100, 1);
    repeat (12) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_req", o_rst_req, 8'hFF);
    chk("mid_clk_en", o_clk_en, 8'h00);
    chk("mid_busy", o_busy, 1);
    chk("mid_done", o_done, 0);
    repeat (3) @(negedge clk);
    boot("reboot");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
